// File: rtl/seven_segment_capture_decoder.sv
// Receive side of a two-digit multiplexed seven-segment bus. Each digit is debounced and
// decoded back to BCD, then the two digits are rebuilt into one value with error and timeout flags.
module seven_segment_capture_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic [1:0] an_in,
    output logic [3:0] units_out,
    output logic [3:0] tens_out,
    output logic [3:0] value_out,
    output logic       value_valid,
    output logic       err_pattern,
    output logic       err_range,
    output logic       stale,
    output logic [1:0] frame_state
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        HALF_U = 2'd1,
        HALF_T = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    an_q, an_p;
    logic [6:0]    seg_q, seg_p;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] tcnt;
    logic          pend_valid, pend_units;
    logic [3:0]    pend_digit;

    logic          sample_ok, same_sample, capture;
    logic          cap_legal, cap_is_units;
    logic [3:0]    cap_digit;
    logic          ev_valid, ev_units;
    logic [3:0]    ev_digit;
    logic [4:0]    sum5;

    // Returns {legal, digit}; digit is 0 for an illegal pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h01:   decode = {1'b1, 4'd0};
            7'h4F:   decode = {1'b1, 4'd1};
            7'h12:   decode = {1'b1, 4'd2};
            7'h06:   decode = {1'b1, 4'd3};
            7'h4C:   decode = {1'b1, 4'd4};
            7'h24:   decode = {1'b1, 4'd5};
            7'h20:   decode = {1'b1, 4'd6};
            7'h0F:   decode = {1'b1, 4'd7};
            7'h00:   decode = {1'b1, 4'd8};
            7'h04:   decode = {1'b1, 4'd9};
            default: decode = 5'd0;
        endcase
    endfunction

    always_comb begin
        sample_ok   = (an_q == 2'b10) || (an_q == 2'b01);
        same_sample = ({an_q, seg_q} == {an_p, seg_p});
        cnt_nxt     = '0;
        if (sample_ok) begin
            if (!same_sample)
                cnt_nxt = CW'(1);
            else if (cnt == CW'(STABLE_CYCLES))
                cnt_nxt = cnt;
            else
                cnt_nxt = cnt + CW'(1);
        end
        // A saturated dwell must not fire again; a fresh dwell may.
        capture = sample_ok && (cnt_nxt == CW'(STABLE_CYCLES)) &&
                  (!same_sample || (cnt != CW'(STABLE_CYCLES)));
        {cap_legal, cap_digit} = decode(seg_q);
        cap_is_units = (an_q == 2'b10);

        // A capture held over from the DONE cycle takes priority in WAIT.
        ev_valid = 1'b0;
        ev_units = 1'b0;
        ev_digit = '0;
        if (state == WAIT && pend_valid) begin
            ev_valid = 1'b1;
            ev_units = pend_units;
            ev_digit = pend_digit;
        end else if (state != DONE && capture && cap_legal) begin
            ev_valid = 1'b1;
            ev_units = cap_is_units;
            ev_digit = cap_digit;
        end

        sum5 = ({1'b0, tens_out} * 5'd10) + {1'b0, units_out};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q        <= '0;
            seg_q       <= '0;
            an_p        <= '0;
            seg_p       <= '0;
            cnt         <= '0;
            state       <= WAIT;
            pend_valid  <= 1'b0;
            pend_units  <= 1'b0;
            pend_digit  <= '0;
            units_out   <= '0;
            tens_out    <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            err_pattern <= 1'b0;
            err_range   <= 1'b0;
            tcnt        <= '0;
            stale       <= 1'b0;
        end else begin
            an_q  <= an_in;
            seg_q <= seg_in;
            an_p  <= an_q;
            seg_p <= seg_q;
            cnt   <= cnt_nxt;

            value_valid <= 1'b0;
            err_range   <= 1'b0;
            err_pattern <= capture && !cap_legal;

            if (ev_valid) begin
                if (ev_units)
                    units_out <= ev_digit;
                else
                    tens_out <= ev_digit;
            end

            pend_valid <= 1'b0;
            if (state == DONE && capture && cap_legal) begin
                pend_valid <= 1'b1;
                pend_units <= cap_is_units;
                pend_digit <= cap_digit;
            end

            case (state)
                WAIT:   if (ev_valid) state <= ev_units ? HALF_U : HALF_T;
                HALF_U: if (ev_valid && !ev_units) state <= DONE;
                HALF_T: if (ev_valid && ev_units) state <= DONE;
                DONE: begin
                    state <= WAIT;
                    if (tens_out <= 4'd1 && sum5 <= 5'd15) begin
                        value_valid <= 1'b1;
                        value_out   <= sum5[3:0];
                    end else begin
                        err_range <= 1'b1;
                    end
                end
            endcase

            // Every frame pulse is issued from DONE, so DONE restarts the timeout.
            if (state == DONE) begin
                tcnt  <= '0;
                stale <= 1'b0;
            end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
                tcnt <= tcnt + TW'(1);
                if (tcnt == TW'(TIMEOUT_CYCLES - 1))
                    stale <= 1'b1;
            end
        end
    end

    assign frame_state = state;

endmodule

// File: tb/tb_seven_segment_capture_decoder.sv
// Bench for seven_segment_capture_decoder: frame vector table, hand-written corner sequences
// and random bus traffic, all checked every cycle against a dwell-level reference model.
module tb_seven_segment_capture_decoder;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1024;
    localparam logic [1:0] AN_U    = 2'b10;
    localparam logic [1:0] AN_T    = 2'b01;
    localparam logic [1:0] AN_IDLE = 2'b11;
    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_HALF_U = 2'd1;
    localparam logic [1:0] ST_HALF_T = 2'd2;

    logic       clk;
    logic       rst;
    logic [6:0] seg_in;
    logic [1:0] an_in;
    logic [3:0] units_out, tens_out, value_out;
    logic       value_valid, err_pattern, err_range, stale;
    logic [1:0] frame_state;

    seven_segment_capture_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .units_out(units_out), .tens_out(tens_out), .value_out(value_out),
        .value_valid(value_valid), .err_pattern(err_pattern), .err_range(err_range),
        .stale(stale), .frame_state(frame_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [3:0] exp_q[$];

    logic [6:0] seg_code [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    // Reference model state: dwell runs, which digits of the frame are held, pending pulses.
    logic [8:0] d1, prev_x;
    int  run;
    bit  have_u, have_t, in_done, pend, pend_u;
    int  pend_d, m_units, m_tens, m_value, nxt_val, anchor;
    bit  nxt_vv, nxt_er, e_vv, e_er, e_ep, e_stale;

    int vv_cnt, er_cnt, ep_cnt, last_frame_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int seg_digit(input logic [6:0] s);
        for (int d = 0; d < 10; d++)
            if (seg_code[d] == s) return d;
        return -1;
    endfunction

    task automatic store(input bit is_u, input int d);
        int v;
        if (is_u) begin m_units = d; have_u = 1; end
        else begin m_tens = d; have_t = 1; end
        if (have_u && have_t) begin
            v = m_tens * 10 + m_units;
            if (m_tens <= 1 && v <= 15) begin
                nxt_vv  = 1;
                nxt_val = v;
                exp_q.push_back(4'(v));
            end else begin
                nxt_er = 1;
            end
            have_u  = 0;
            have_t  = 0;
            in_done = 1;
        end
    endtask

    task automatic model_step();
        logic [8:0] x;
        bit was_done, ok;
        int d;
        if (rst) begin
            d1 = '0; prev_x = '0; run = 0;
            have_u = 0; have_t = 0; in_done = 0; pend = 0; pend_u = 0; pend_d = 0;
            m_units = 0; m_tens = 0; m_value = 0; nxt_val = 0;
            nxt_vv = 0; nxt_er = 0; e_vv = 0; e_er = 0; e_ep = 0; e_stale = 0;
            anchor = cyc;
            exp_q.delete();
            return;
        end
        e_vv = nxt_vv;
        e_er = nxt_er;
        if (nxt_vv) m_value = nxt_val;
        nxt_vv = 0;
        nxt_er = 0;
        if (e_vv || e_er) anchor = cyc;
        e_stale = (cyc - anchor) >= TIMEOUT;

        was_done = in_done;
        in_done  = 0;
        if (pend && !was_done) begin
            pend = 0;
            store(pend_u, pend_d);
        end

        // The sample judged at this edge is the bus value from two cycles back.
        x  = d1;
        d1 = {an_in, seg_in};
        ok = (x[8:7] == 2'b10) || (x[8:7] == 2'b01);
        if (ok) run = (x == prev_x) ? run + 1 : 1;
        else run = 0;
        prev_x = x;

        e_ep = 0;
        if (run == STABLE) begin
            d = seg_digit(x[6:0]);
            if (d < 0) e_ep = 1;
            else if (was_done) begin pend = 1; pend_u = (x[8:7] == 2'b10); pend_d = d; end
            else store(x[8:7] == 2'b10, d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        chk("units_out", units_out, m_units);
        chk("tens_out", tens_out, m_tens);
        chk("value_out", value_out, m_value);
        chk("value_valid", value_valid, e_vv);
        chk("err_range", err_range, e_er);
        chk("err_pattern", err_pattern, e_ep);
        chk("stale", stale, e_stale);
        if (value_valid === 1'b1) begin
            vv_cnt++;
            if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
            else chk("sb_value", value_out, exp_q.pop_front());
        end
        if (err_range === 1'b1) er_cnt++;
        if (err_pattern === 1'b1) ep_cnt++;
        if (value_valid === 1'b1 || err_range === 1'b1) last_frame_cyc = cyc;
    endtask

    task automatic dwell(input logic [1:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) tick();
    endtask

    task automatic clear_tally();
        vv_cnt = 0;
        er_cnt = 0;
        ep_cnt = 0;
    endtask

    task automatic frame(input logic [6:0] t_seg, input logic [6:0] u_seg);
        dwell(AN_T, t_seg, 8);
        dwell(AN_U, u_seg, 8);
        dwell(AN_IDLE, 7'h7F, 4);
    endtask

    typedef struct {
        logic [6:0] t_seg;
        logic [6:0] u_seg;
        bit         units_first;
        int         t_dig;
        int         u_dig;
        int         n_vv;
        int         n_er;
        int         val;
    } frame_vec_t;

    frame_vec_t vecs [8];

    initial begin
        vecs[0] = '{7'h4F, 7'h06, 0, 1, 3, 1, 0, 13};
        vecs[1] = '{7'h4F, 7'h24, 1, 1, 5, 1, 0, 15};
        vecs[2] = '{7'h01, 7'h00, 0, 0, 8, 1, 0, 8};
        vecs[3] = '{7'h4F, 7'h20, 0, 1, 6, 0, 1, 8};
        vecs[4] = '{7'h12, 7'h01, 0, 2, 0, 0, 1, 8};
        vecs[5] = '{7'h01, 7'h01, 1, 0, 0, 1, 0, 0};
        vecs[6] = '{7'h4F, 7'h01, 0, 1, 0, 1, 0, 10};
        vecs[7] = '{7'h04, 7'h04, 0, 9, 9, 0, 1, 10};

        rst    = 1'b1;
        an_in  = AN_IDLE;
        seg_in = 7'h7F;
        last_frame_cyc = 0;
        clear_tally();
        repeat (3) tick();
        chk("rst_units", units_out, 0);
        chk("rst_value", value_out, 0);
        chk("rst_flags", {value_valid, err_pattern, err_range, stale}, 0);
        chk("rst_state", frame_state, ST_WAIT);
        rst = 1'b0;
        dwell(AN_IDLE, 7'h7F, 2);

        for (int i = 0; i < 8; i++) begin
            clear_tally();
            if (vecs[i].units_first) begin
                dwell(AN_U, vecs[i].u_seg, 8);
                dwell(AN_T, vecs[i].t_seg, 8);
            end else begin
                dwell(AN_T, vecs[i].t_seg, 8);
                dwell(AN_U, vecs[i].u_seg, 8);
            end
            dwell(AN_IDLE, 7'h7F, 4);
            chk($sformatf("vec%0d_valid", i), vv_cnt, vecs[i].n_vv);
            chk($sformatf("vec%0d_range", i), er_cnt, vecs[i].n_er);
            chk($sformatf("vec%0d_value", i), value_out, vecs[i].val);
            chk($sformatf("vec%0d_tens", i), tens_out, vecs[i].t_dig);
            chk($sformatf("vec%0d_units", i), units_out, vecs[i].u_dig);
        end

        // Short dwell must not capture; the following long one must.
        clear_tally();
        dwell(AN_U, 7'h4C, 3);
        dwell(AN_IDLE, 7'h7F, 3);
        chk("short_dwell_units", units_out, 9);
        dwell(AN_U, 7'h4C, 8);
        chk("long_dwell_units", units_out, 4);
        dwell(AN_T, 7'h4F, 8);
        dwell(AN_IDLE, 7'h7F, 4);
        chk("long_dwell_valid", vv_cnt, 1);
        chk("long_dwell_value", value_out, 14);

        // Illegal pattern: one error pulse per dwell, frame untouched.
        clear_tally();
        dwell(AN_U, 7'h7F, 8);
        chk("badpat_state", frame_state, ST_WAIT);
        dwell(AN_IDLE, 7'h7F, 3);
        dwell(AN_U, 7'h7F, 8);
        dwell(AN_IDLE, 7'h7F, 3);
        chk("badpat_pulses", ep_cnt, 2);
        chk("badpat_state2", frame_state, ST_WAIT);
        chk("badpat_units", units_out, 4);
        chk("badpat_frames", vv_cnt + er_cnt, 0);

        // Anode gaps split a dwell; reset in HALF_U drops the partial frame.
        clear_tally();
        dwell(AN_U, 7'h24, 2);
        dwell(2'b00, 7'h24, 3);
        dwell(AN_U, 7'h24, 2);
        dwell(AN_IDLE, 7'h24, 3);
        chk("gap_no_capture", units_out, 4);
        dwell(AN_U, 7'h24, 8);
        chk("gap_capture", units_out, 5);
        chk("half_u_state", frame_state, ST_HALF_U);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("midrst_digits", {tens_out, units_out, value_out}, 0);
        chk("midrst_flags", {value_valid, err_pattern, err_range, stale}, 0);
        chk("midrst_state", frame_state, ST_WAIT);
        clear_tally();
        dwell(AN_T, 7'h4F, 8);
        dwell(AN_IDLE, 7'h7F, 4);
        chk("midrst_no_frame", vv_cnt, 0);
        chk("half_t_state", frame_state, ST_HALF_T);
        dwell(AN_U, 7'h24, 8);
        dwell(AN_IDLE, 7'h7F, 4);
        chk("midrst_refill_value", value_out, 15);

        // Random traffic, checked cycle by cycle by the model.
        for (int n = 0; n < 250; n++) begin
            int r;
            int dg;
            logic [1:0] an;
            logic [6:0] s;
            r  = $urandom_range(0, 9);
            an = (r < 4) ? AN_U : (r < 8) ? AN_T : (r == 8) ? 2'b00 : 2'b11;
            dg = (an == AN_T && $urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : $urandom_range(0, 9);
            s  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_code[dg];
            dwell(an, s, $urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        // Timeout: stale rises exactly TIMEOUT cycles after the last frame pulse.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        clear_tally();
        frame(7'h4F, 7'h06);
        chk("pre_stale_valid", vv_cnt, 1);
        for (int k = 0; k < 2 * TIMEOUT && cyc < last_frame_cyc + TIMEOUT - 1; k++)
            dwell(AN_IDLE, 7'h7F, 1);
        chk("stale_before_limit", stale, 0);
        dwell(AN_IDLE, 7'h7F, 1);
        chk("stale_at_limit", stale, 1);
        chk("stale_timing", cyc - last_frame_cyc, TIMEOUT);
        clear_tally();
        frame(7'h01, 7'h0F);
        chk("stale_cleared", stale, 0);
        chk("post_stale_value", value_out, 7);
        chk("post_stale_valid", vv_cnt, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
